tuner_tx_2: RTL
===============

Name: tuner_tx_2

Overview:
- Complex -> real upconverter for the transmit path; the mirror of the receive-side real -> complex tuner.
- Takes baseband I/Q samples, synthesises cos/sin from a noise-shaped NCO, and forms out = I*cos - Q*sin.
- The rounded, saturated real sample feeds the DAC interface.
- Sample-rate agnostic: the NCO advances only on input strobes.

Parameters:
- dsz, 10, data width of I/Q in and real out (signed)
- fsz, 26, phase accumulator / frequency word width
- psz, 12, phase bits used to address the sine table

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset; reset==0 at a clk edge resets
- ena  input  1  input-sample strobe; i_in/q_in valid when high
- i_in  input  dsz  signed in-phase sample
- q_in  input  dsz  signed quadrature sample
- frq  input  fsz  unsigned tuning word; Fout = frq*Fs/2^fsz
- ns_ena  input  1  phase noise-shaping enable
- out  output  dsz  signed real upconverted sample
- valid_out  output  1  out valid strobe

Behaviour:
- Reset (reset==0 at a clk edge):
  - acc, noise-shaping residue, all pipeline data and valid bits cleared to 0.
  - out=0, valid_out=0 the cycle after.
  - In-flight samples are discarded, not flushed.
- Phase, for the k-th accepted sample after reset (k=0,1,...):
  - acc_k = sum of frq at samples 0..k-1, mod 2^fsz; acc_0 = 0.
  - acc advances by frq only on cycles with ena=1; frq is sampled on that same cycle.
  - p_k = acc_k + (ns_ena ? sign_extend(r_{k-1}) : 0), mod 2^fsz.
  - r_{k-1} = low fsz-psz bits of p_{k-1}, treated as signed; r_{-1} = 0.
  - phs_k = p_k[fsz-1 : fsz-psz].
  - Residue updates only on accepted samples.
- Sine table:
  - S[p] = round(A*sin(2*pi*(p+0.5)/2^psz)), A = 2^(dsz-1)-1, p in 0..2^psz-1.
  - sin_k = S[phs_k]; cos_k = S[(phs_k + 2^(psz-2)) mod 2^psz].
  - Implementer may store a quarter-wave table with sign/mirror logic; results must be bit-identical to S.
- Mix:
  - prod = i_in*cos - q_in*sin, full precision (2*dsz+1 bits).
  - y = (prod + 2^(dsz-2)) >>> (dsz-1), arithmetic shift (round half up).
  - out = clamp(y, -(2^(dsz-1)-1), +(2^(dsz-1)-1)); symmetric, most-negative code never emitted.
- Latency: fixed 4 clk.
  - Sample accepted at edge n appears on out with valid_out=1 after edge n+4.
  - The pipeline runs every cycle; valid flag travels with data.
  - I/Q are delayed internally to align with their table outputs.
- ena low: no acc/residue update.
  - valid_out=0 in the corresponding output slot.
  - out holds its last value when valid_out=0.
- Back-to-back ena (every cycle) sustains 1 sample/clk, no stalls.
- frq change takes effect on the next accepted sample, phase-continuous (no acc reset).
- Wrap-around: acc and p wrap modulo 2^fsz silently.
- ns_ena toggling mid-stream applies from the next accepted sample; residue register keeps updating regardless.

Test Plan (dsz=10, fsz=26, psz=12, so A=511):
- Reset: hold reset=0 5 cycles with ena=1 and random inputs -> out=0, valid_out=0 throughout and for 4 cycles after release.
- DC carrier: frq=0, ns_ena=0, I=100, Q=0, ena=1 -> first valid_out 4 cycles after the first ena; out=100 constant.
- Fs/4 tone: frq=2^24, I=200, Q=0, ns_ena=0, ena every cycle -> out repeats 200, 0, -200, 0. Repeat with I=0, Q=200 -> 0, -200, 0, 200.
- Saturation: frq=2^23, I=511, Q=-511 -> second sample (phs=512) gives out=+511. With I=-511, Q=511 -> out=-511; never -512.
- Gapped strobes / noise shaping: ena every 3rd cycle, Fs/4 setup -> same 200, 0, -200, 0 sequence with valid_out every 3rd cycle. Repeat with ns_ena=1 (residue is always 0) -> identical output.
- Reset mid-stream: during the Fs/4 test, drive reset=0 for 1 cycle -> valid_out=0 until 4 cycles after the next ena; the first output after recovery is 200 (phase restarts at 0).

Source files
------------

// File: rtl/tuner_tx_2.sv
// Complex-to-real transmit upconverter: noise-shaped NCO, quarter-wave sine table,
// out = I*cos - Q*sin, rounded and symmetrically saturated, fixed 4-clock latency.
module tuner_tx_2 #(
    parameter int dsz = 10,
    parameter int fsz = 26,
    parameter int psz = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic signed [dsz-1:0] i_in,
    input  logic signed [dsz-1:0] q_in,
    input  logic [fsz-1:0]        frq,
    input  logic                  ns_ena,
    output logic signed [dsz-1:0] out,
    output logic                  valid_out
);
    localparam int rsz = fsz - psz;
    localparam int qsz = psz - 2;
    localparam int amp = 2 ** (dsz - 1) - 1;
    localparam int wsz = 2 * dsz + 1;
    localparam real two_pi = 6.283185307179586;
    localparam logic [psz-1:0] quarter_turn = psz'(2 ** qsz);
    localparam logic signed [wsz-1:0] round_half = wsz'(2 ** (dsz - 2));
    localparam logic signed [wsz-1:0] pos_lim = wsz'(amp);
    localparam logic signed [wsz-1:0] neg_lim = wsz'(-amp);

    // First-quadrant magnitudes; the other quadrants are mirrored/negated copies.
    logic [dsz-2:0] qtab [0:2**qsz-1];
    genvar g;
    generate
        for (g = 0; g < 2 ** qsz; g++) begin : g_qtab
            assign qtab[g] = (dsz-1)'($rtoi(real'(amp) *
                             $sin(two_pi * (real'(g) + 0.5) / real'(2 ** psz)) + 0.5));
        end
    endgenerate

    function automatic logic [qsz-1:0] quad_index(input logic [psz-1:0] ph);
        return ph[psz-2] ? ~ph[qsz-1:0] : ph[qsz-1:0];
    endfunction

    function automatic logic signed [dsz-1:0] apply_sign(input logic neg, input logic [dsz-2:0] mag);
        logic signed [dsz-1:0] m;
        m = $signed({1'b0, mag});
        return neg ? -m : m;
    endfunction

    logic [fsz-1:0]         acc_r;
    logic [rsz-1:0]         res_r;
    logic [psz-1:0]         phs_r;
    logic                   v1_r, v2_r, v3_r, v4_r;
    logic signed [dsz-1:0]  i1_r, q1_r, i2_r, q2_r;
    logic signed [dsz-1:0]  sin_r, cos_r;
    logic signed [2*dsz-1:0] ic_r, qs_r;
    logic signed [wsz-1:0]  diff_r;

    logic [fsz-1:0]         p_s;
    logic [psz-1:0]         cos_ph_s;
    logic signed [wsz-1:0]  y_s;
    logic signed [dsz-1:0]  sat_s;

    // Dithered phase: accumulator plus the previous sample's signed residue.
    always_comb begin
        p_s = acc_r;
        if (ns_ena) begin
            p_s = acc_r + {{psz{res_r[rsz-1]}}, res_r};
        end else begin
            p_s = acc_r;
        end
        cos_ph_s = phs_r + quarter_turn;
    end

    // Round half up, then clamp so the most negative code never appears.
    always_comb begin
        y_s = (diff_r + round_half) >>> (dsz - 1);
        if (y_s > pos_lim) begin
            sat_s = dsz'(pos_lim);
        end else if (y_s < neg_lim) begin
            sat_s = dsz'(neg_lim);
        end else begin
            sat_s = dsz'(y_s);
        end
    end

    // NCO, table lookup, multiply, subtract and output stages.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_r     <= {fsz{1'b0}};
            res_r     <= {rsz{1'b0}};
            phs_r     <= {psz{1'b0}};
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            v3_r      <= 1'b0;
            v4_r      <= 1'b0;
            i1_r      <= {dsz{1'b0}};
            q1_r      <= {dsz{1'b0}};
            i2_r      <= {dsz{1'b0}};
            q2_r      <= {dsz{1'b0}};
            sin_r     <= {dsz{1'b0}};
            cos_r     <= {dsz{1'b0}};
            ic_r      <= {(2*dsz){1'b0}};
            qs_r      <= {(2*dsz){1'b0}};
            diff_r    <= {wsz{1'b0}};
            out       <= {dsz{1'b0}};
            valid_out <= 1'b0;
        end else begin
            if (ena) begin
                acc_r <= acc_r + frq;
                res_r <= p_s[rsz-1:0];
                phs_r <= p_s[fsz-1:rsz];
                i1_r  <= i_in;
                q1_r  <= q_in;
            end else begin
                acc_r <= acc_r;
                res_r <= res_r;
                phs_r <= phs_r;
                i1_r  <= i1_r;
                q1_r  <= q1_r;
            end
            v1_r   <= ena;
            sin_r  <= apply_sign(phs_r[psz-1], qtab[quad_index(phs_r)]);
            cos_r  <= apply_sign(cos_ph_s[psz-1], qtab[quad_index(cos_ph_s)]);
            i2_r   <= i1_r;
            q2_r   <= q1_r;
            v2_r   <= v1_r;
            ic_r   <= i2_r * cos_r;
            qs_r   <= q2_r * sin_r;
            v3_r   <= v2_r;
            diff_r <= wsz'(ic_r) - wsz'(qs_r);
            v4_r   <= v3_r;
            valid_out <= v4_r;
            if (v4_r) begin
                out <= sat_s;
            end else begin
                out <= out;
            end
        end
    end
endmodule
